// File: rtl/rock_scheduler_pkg.sv
// rtl/rock_scheduler_pkg.sv - shared types, constants and step helper for the rocking scheduler
package rock_pkg;

  localparam int LEVEL_W     = 3;
  localparam int LEVEL_MAX   = 7;
  localparam int START_LEVEL = 3;
  localparam int TRIES_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_WAITSTAB = 3'd2,
    ST_EVAL     = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RAMP     = 3'd5,
    ST_FAIL     = 3'd6
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef struct packed {
    logic [LEVEL_W-1:0] level;
    dir_t               dir;
  } step_t;

  // One level step in direction d; bouncing off 1 or LEVEL_MAX reverses the direction.
  function automatic step_t step_level(input logic [LEVEL_W-1:0] lvl, input dir_t d);
    step_t s;
    if (d == DIR_UP) begin
      if (lvl >= LEVEL_W'(LEVEL_MAX)) begin
        s.level = lvl - LEVEL_W'(1);
        s.dir   = DIR_DOWN;
      end else begin
        s.level = lvl + LEVEL_W'(1);
        s.dir   = DIR_UP;
      end
    end else begin
      if (lvl <= LEVEL_W'(1)) begin
        s.level = lvl + LEVEL_W'(1);
        s.dir   = DIR_UP;
      end else begin
        s.level = lvl - LEVEL_W'(1);
        s.dir   = DIR_DOWN;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/rock_scheduler_if.sv
// rtl/rock_scheduler_if.sv - stress-detector inputs and drive outputs of the rocking scheduler
interface rock_scheduler_if;
  import rock_pkg::*;

  logic               tick;
  logic               enable;
  logic [5:0]         hart;
  logic               stable_pulse;
  logic               dropped;
  logic               rose;
  logic [LEVEL_W-1:0] level;
  logic               rocking;
  logic               calm;
  logic               fail;

  modport master (
    output tick, enable, hart, stable_pulse, dropped, rose,
    input  level, rocking, calm, fail
  );

  modport slave (
    input  tick, enable, hart, stable_pulse, dropped, rose,
    output level, rocking, calm, fail
  );

endinterface

// File: rtl/rock_scheduler_tick_counter.sv
// rtl/rock_scheduler_tick_counter.sv - loadable tick-enabled down-counter with zero flag
module tick_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over a same-cycle tick; otherwise count down on tick and park at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rock_scheduler.sv
// rtl/rock_scheduler.sv - closed-loop cradle rocking controller; ROCK_SCHED_RAMPDOWN_EN adds gradual ramp-down
module rock_scheduler
  import rock_pkg::*;
#(
  parameter int SETTLE_TICKS  = 16,
  parameter int HOLD_TICKS    = 64,
  parameter int RAMP_TICKS    = 4,
  parameter int MAX_TRIES     = 6,
  parameter int STRESS_THRESH = 40,
  parameter int CALM_THRESH   = 20
) (
  input logic             clk,
  input logic             reset,
  rock_scheduler_if.slave bus
);

  // One counter serves every timed state, so size it for the longest window.
  localparam int CNT_MAX = (SETTLE_TICKS > HOLD_TICKS)
                         ? ((SETTLE_TICKS > RAMP_TICKS) ? SETTLE_TICKS : RAMP_TICKS)
                         : ((HOLD_TICKS > RAMP_TICKS) ? HOLD_TICKS : RAMP_TICKS);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_TICKS);
  localparam logic [CNT_W-1:0]   HOLD_LD   = CNT_W'(HOLD_TICKS);
`ifdef ROCK_SCHED_RAMPDOWN_EN
  localparam logic [CNT_W-1:0]   RAMP_LD   = CNT_W'(RAMP_TICKS);
`endif
  localparam logic [5:0]         STRESS_T  = 6'(STRESS_THRESH);
  localparam logic [5:0]         CALM_T    = 6'(CALM_THRESH);
  // tries is compared with ==, so MAX_TRIES must lie in 1..7.
  localparam logic [TRIES_W-1:0] MAX_T     = TRIES_W'(MAX_TRIES);

  state_t             state_q, state_n;
  logic [LEVEL_W-1:0] level_q, level_n;
  dir_t               dir_q, dir_n;
  logic [TRIES_W-1:0] tries_q, tries_n, tries_inc;
  logic               fail_q, fail_n;
  logic               calm_q, rocking_q;
  logic               ev_calm_q, ev_calm_n;
  logic               ev_drop_q, ev_drop_n;
  logic               ev_rose_q, ev_rose_n;
  logic               cnt_load, cnt_zero;
  logic [CNT_W-1:0]   cnt_val;
  logic               stress;
  dir_t               step_dir;
  step_t              step;

  tick_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .tick     (bus.tick),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign stress    = bus.stable_pulse && (bus.hart >= STRESS_T);
  assign step_dir  = ev_rose_q ? dir_t'(~dir_q) : dir_q;
  assign step      = step_level(level_q, step_dir);
  assign tries_inc = tries_q + TRIES_W'(1);

  // Next-state and counter-load decode; enable low overrides every state.
  always_comb begin
    state_n   = state_q;
    level_n   = level_q;
    dir_n     = dir_q;
    tries_n   = tries_q;
    fail_n    = fail_q;
    ev_calm_n = ev_calm_q;
    ev_drop_n = ev_drop_q;
    ev_rose_n = ev_rose_q;
    cnt_load  = 1'b0;
    cnt_val   = SETTLE_LD;
    if (!bus.enable) begin
      state_n = ST_IDLE;
      level_n = '0;
      dir_n   = DIR_UP;
      tries_n = '0;
      fail_n  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          level_n = '0;
          tries_n = '0;
          dir_n   = DIR_UP;
          if (stress) begin
            level_n  = LEVEL_W'(START_LEVEL);
            cnt_load = 1'b1;
            state_n  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            state_n  = ST_WAITSTAB;
          end
        end
        ST_WAITSTAB: begin
          // Latch the detector verdict; a silent window is treated as a rise.
          if (bus.stable_pulse) begin
            ev_calm_n = (bus.hart < CALM_T);
            ev_drop_n = bus.dropped;
            ev_rose_n = bus.rose;
            state_n   = ST_EVAL;
          end else if (cnt_zero) begin
            ev_calm_n = 1'b0;
            ev_drop_n = 1'b0;
            ev_rose_n = 1'b1;
            state_n   = ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (ev_calm_q) begin
            cnt_val  = HOLD_LD;
            cnt_load = 1'b1;
            state_n  = ST_HOLD;
          end else if (ev_drop_q) begin
            cnt_load = 1'b1;
            state_n  = ST_SETTLE;
          end else begin
            tries_n = tries_inc;
            if (tries_inc == MAX_T) begin
              level_n = '0;
              fail_n  = 1'b1;
              state_n = ST_FAIL;
            end else begin
              level_n  = step.level;
              dir_n    = step.dir;
              cnt_load = 1'b1;
              state_n  = ST_SETTLE;
            end
          end
        end
        ST_HOLD: begin
          if (stress) begin
            tries_n  = '0;
            cnt_load = 1'b1;
            state_n  = ST_SETTLE;
          end else if (cnt_zero) begin
`ifdef ROCK_SCHED_RAMPDOWN_EN
            cnt_val  = RAMP_LD;
            cnt_load = 1'b1;
            state_n  = ST_RAMP;
`else
            level_n  = '0;
            state_n  = ST_IDLE;
`endif
          end
        end
`ifdef ROCK_SCHED_RAMPDOWN_EN
        ST_RAMP: begin
          if (stress) begin
            tries_n  = '0;
            cnt_load = 1'b1;
            state_n  = ST_SETTLE;
          end else if (cnt_zero) begin
            level_n = level_q - LEVEL_W'(1);
            if (level_q <= LEVEL_W'(1)) begin
              level_n = '0;
              state_n = ST_IDLE;
            end else begin
              cnt_val  = RAMP_LD;
              cnt_load = 1'b1;
            end
          end
        end
`endif
        ST_FAIL: begin
          level_n = '0;
          fail_n  = 1'b1;
        end
        default: begin
          state_n = ST_IDLE;
          level_n = '0;
        end
      endcase
    end
  end

  // State and registered outputs; rocking/calm come from next-state so they line up with level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      dir_q     <= DIR_UP;
      tries_q   <= '0;
      fail_q    <= 1'b0;
      calm_q    <= 1'b0;
      rocking_q <= 1'b0;
      ev_calm_q <= 1'b0;
      ev_drop_q <= 1'b0;
      ev_rose_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      level_q   <= level_n;
      dir_q     <= dir_n;
      tries_q   <= tries_n;
      fail_q    <= fail_n;
      calm_q    <= (state_n == ST_HOLD);
      rocking_q <= (level_n != '0);
      ev_calm_q <= ev_calm_n;
      ev_drop_q <= ev_drop_n;
      ev_rose_q <= ev_rose_n;
    end
  end

  assign bus.level   = level_q;
  assign bus.rocking = rocking_q;
  assign bus.calm    = calm_q;
  assign bus.fail    = fail_q;

endmodule
